// File: rtl/fir_tap_multiplier.sv
// fir_tap_multiplier: 10-tap sample delay line with per-tap signed 8x8 products and add/accumulate sequencing strobes.
module fir_tap_multiplier (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic        iEnSample,
    input  logic [7:0]  iFirIn,
    input  logic        iCoeffWr,
    input  logic [3:0]  iCoeffAddr,
    input  logic [7:0]  iCoeffData,
    output logic [15:0] oMul_0,
    output logic [15:0] oMul_1,
    output logic [15:0] oMul_2,
    output logic [15:0] oMul_3,
    output logic [15:0] oMul_4,
    output logic [15:0] oMul_5,
    output logic [15:0] oMul_6,
    output logic [15:0] oMul_7,
    output logic [15:0] oMul_8,
    output logic [15:0] oMul_9,
    output logic        oEnMul,
    output logic        oEnAdd,
    output logic        oEnAcc,
    output logic        oBusy,
    output logic        oSmpDrop
);
    typedef enum logic [2:0] {IDLE, SHIFT, MUL, ADD, ACC} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic signed [7:0]  sample_q;
    logic signed [7:0]  tap_q [10];
    logic signed [7:0]  tap_d [10];
    logic signed [7:0]  coeff_q [10];
    logic signed [15:0] mul_q [10];
    logic signed [15:0] prod [10];
    logic               en_mul_q, en_add_q, en_acc_q, busy_q, drop_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = iEnSample ? SHIFT : IDLE;
            SHIFT:   state_d = MUL;
            MUL:     state_d = ADD;
            ADD:     state_d = (cnt_q == 4'd9) ? ACC : ADD;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == ADD) ? cnt_q + 4'd1 : 4'd0;
    end

    // Products are formed from the post-shift taps so they are already valid while oEnMul is high.
    always_comb begin
        tap_d[0] = sample_q;
        for (int k = 1; k < 10; k++) tap_d[k] = tap_q[k-1];
        for (int k = 0; k < 10; k++) prod[k] = tap_d[k] * coeff_q[k];
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            tap_q    <= '{default: '0};
            coeff_q  <= '{default: '0};
            mul_q    <= '{default: '0};
            en_mul_q <= 1'b0;
            en_add_q <= 1'b0;
            en_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && iEnSample) sample_q <= iFirIn;
            if (state_q == IDLE && iCoeffWr && iCoeffAddr <= 4'd9) coeff_q[iCoeffAddr] <= iCoeffData;
            if (state_q == SHIFT) begin
                tap_q <= tap_d;
                mul_q <= prod;
            end
            en_mul_q <= state_d == MUL;
            en_add_q <= state_d == ADD;
            en_acc_q <= state_d == ACC;
            busy_q   <= state_d != IDLE;
            drop_q   <= iEnSample && state_q != IDLE;
        end
    end

    assign oMul_0   = mul_q[0];
    assign oMul_1   = mul_q[1];
    assign oMul_2   = mul_q[2];
    assign oMul_3   = mul_q[3];
    assign oMul_4   = mul_q[4];
    assign oMul_5   = mul_q[5];
    assign oMul_6   = mul_q[6];
    assign oMul_7   = mul_q[7];
    assign oMul_8   = mul_q[8];
    assign oMul_9   = mul_q[9];
    assign oEnMul   = en_mul_q;
    assign oEnAdd   = en_add_q;
    assign oEnAcc   = en_acc_q;
    assign oBusy    = busy_q;
    assign oSmpDrop = drop_q;
endmodule

// File: tb/tb_fir_tap_multiplier.sv
// tb_fir_tap_multiplier: directed vectors for the tap multiplier; timing offsets are counted in cycles after the strobe cycle.
module tb_fir_tap_multiplier;
    logic        clk = 1'b0;
    logic        rsn;
    logic        en_sample;
    logic [7:0]  fir_in;
    logic        coeff_wr;
    logic [3:0]  coeff_addr;
    logic [7:0]  coeff_data;
    logic [15:0] mul [10];
    logic        en_mul, en_add, en_acc, busy, smp_drop;
    int          total = 0;
    int          bad = 0;
    logic signed [7:0] mtap [10];
    logic signed [7:0] mco [10];

    always #5 clk = ~clk;

    fir_tap_multiplier dut (
        .iClk12M(clk), .iRsn(rsn), .iEnSample(en_sample), .iFirIn(fir_in),
        .iCoeffWr(coeff_wr), .iCoeffAddr(coeff_addr), .iCoeffData(coeff_data),
        .oMul_0(mul[0]), .oMul_1(mul[1]), .oMul_2(mul[2]), .oMul_3(mul[3]), .oMul_4(mul[4]),
        .oMul_5(mul[5]), .oMul_6(mul[6]), .oMul_7(mul[7]), .oMul_8(mul[8]), .oMul_9(mul[9]),
        .oEnMul(en_mul), .oEnAdd(en_add), .oEnAcc(en_acc), .oBusy(busy), .oSmpDrop(smp_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_flags"}, {27'd0, en_mul, en_add, en_acc, busy, smp_drop}, 32'd0);
        for (int k = 0; k < 10; k++) chk($sformatf("%s_mul%0d", tag, k), {16'd0, mul[k]}, 32'd0);
    endtask

    task automatic chk_products(input string tag);
        logic [15:0] e;
        for (int k = 0; k < 10; k++) begin
            e = mtap[k] * mco[k];
            chk($sformatf("%s_mul%0d", tag, k), {16'd0, mul[k]}, {16'd0, e});
        end
    endtask

    task automatic wr_coeff(input logic [3:0] a, input logic [7:0] d);
        coeff_wr = 1'b1; coeff_addr = a; coeff_data = d;
        if (a <= 4'd9) mco[a] = d;
        @(posedge clk); #1;
        coeff_wr = 1'b0;
    endtask

    // mid_kind: 0 none, 1 second strobe, 2 coeff write to addr 3, 3 reset assertion
    task automatic run(input string tag, input logic [7:0] x, input logic cw, input logic [3:0] ca,
                       input logic [7:0] cd, input int mid_off, input int mid_kind);
        int mul_at, acc_at, add_first, add_n, busy_n, drop_n, excl;
        mul_at = 0; acc_at = 0; add_first = 0; add_n = 0; busy_n = 0; drop_n = 0; excl = 0;
        fir_in = x; en_sample = 1'b1;
        coeff_wr = cw; coeff_addr = ca; coeff_data = cd;
        if (cw && ca <= 4'd9) mco[ca] = cd;
        @(posedge clk); #1;
        en_sample = 1'b0; coeff_wr = 1'b0;
        for (int off = 1; off <= 14; off++) begin
            if (off == mid_off && mid_kind == 1) begin
                en_sample = 1'b1; fir_in = 8'd99;
            end
            if (off == mid_off && mid_kind == 2) begin
                coeff_wr = 1'b1; coeff_addr = 4'd3; coeff_data = 8'h55;
            end
            if (off == mid_off && mid_kind == 3) begin
                rsn = 1'b0; #1;
                chk_outs_zero({tag, "_rst"});
                mtap = '{default: '0};
                mco = '{default: '0};
                @(posedge clk); #1;
                rsn = 1'b1;
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (en_acc || busy) acc_at++;
                end
                chk({tag, "_post_rst_active"}, acc_at, 0);
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (en_mul) mul_at = off;
            if (en_acc) acc_at = off;
            if (en_add && add_first == 0) add_first = off;
            if (en_add) add_n++;
            if (busy) busy_n++;
            if (smp_drop) drop_n++;
            if (int'(en_mul) + int'(en_add) + int'(en_acc) > 1) excl++;
            @(posedge clk); #1;
            en_sample = 1'b0; coeff_wr = 1'b0;
        end
        for (int k = 9; k > 0; k--) mtap[k] = mtap[k-1];
        mtap[0] = x;
        chk({tag, "_mul_at"}, mul_at, 2);
        chk({tag, "_add_first"}, add_first, 3);
        chk({tag, "_add_n"}, add_n, 10);
        chk({tag, "_acc_at"}, acc_at, 13);
        chk({tag, "_busy_n"}, busy_n, 13);
        chk({tag, "_drop_n"}, drop_n, (mid_kind == 1) ? 1 : 0);
        chk({tag, "_excl"}, excl, 0);
        chk_products(tag);
    endtask

    initial begin
        rsn = 1'b0; en_sample = 1'b0; fir_in = '0;
        coeff_wr = 1'b0; coeff_addr = '0; coeff_data = '0;
        mtap = '{default: '0};
        mco = '{default: '0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs_zero("reset");
        @(posedge clk); #1;
        rsn = 1'b1;
        run("first", 8'd3, 1'b1, 4'd0, 8'd1, 0, 0);
        chk("first_hand", {16'd0, mul[0]}, 32'd3);
        for (int k = 1; k < 10; k++) wr_coeff(4'(k), 8'(k + 1));
        run("imp0", 8'd1, 1'b0, 4'd0, 8'd0, 0, 0);
        chk("imp0_hand", {16'd0, mul[0]}, 32'd1);
        for (int j = 1; j < 4; j++) begin
            run($sformatf("imp%0d", j), 8'd0, 1'b0, 4'd0, 8'd0, 0, 0);
            chk($sformatf("imp%0d_hand", j), {16'd0, mul[j]}, j + 1);
        end
        wr_coeff(4'd0, 8'h80);
        run("negneg", 8'h80, 1'b0, 4'd0, 8'd0, 0, 0);
        chk("negneg_hand", {16'd0, mul[0]}, 32'h4000);
        run("posneg", 8'h80, 1'b1, 4'd0, 8'd127, 0, 0);
        chk("posneg_hand", {16'd0, mul[0]}, 32'hC080);
        run("overrun", 8'd5, 1'b0, 4'd0, 8'd0, 4, 1);
        run("wr_in_add", 8'd9, 1'b0, 4'd0, 8'd0, 5, 2);
        wr_coeff(4'd12, 8'h77);
        run("wr_coinc", 8'd2, 1'b1, 4'd3, 8'hFD, 0, 0);
        chk("wr_coinc_hand", {16'd0, mul[3]}, 32'h0180);
        run("rst_mid", 8'd4, 1'b0, 4'd0, 8'd0, 6, 3);
        wr_coeff(4'd0, 8'd2);
        run("after_rst", 8'd7, 1'b0, 4'd0, 8'd0, 0, 0);
        chk("after_rst_hand", {16'd0, mul[0]}, 32'd14);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
